seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed 7-segment display driver for the stopwatch. It accepts N_FIELDS binary fields, such as hours, minutes and seconds. Each field is converted to two BCD digits with a multi-cycle shift-add-3 engine, and the results are committed atomically to display registers. The block scans the common-anode digits at a programmable refresh rate and supports per-field blinking for set mode. It sits between the stopwatch counters and the board's segment/anode pins, and replaces the fixed four-digit combinational display.

## Interface
- N_FIELDS, 2: number of binary fields; each field drives 2 digits, so 2*N_FIELDS digits in total.
- FIELD_W, 6: bits per field; legal range 4..7.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be at least 2.
- BLINK_DIV, 250: refresh ticks per blink half-period; must be at least 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- field_bus  in  N_FIELDS*FIELD_W  packed fields; field f occupies bits [f*FIELD_W +: FIELD_W].
- load  in  1  single-cycle request to convert and display field_bus.
- blink_en  in  1  global blink enable.
- blink_mask  in  N_FIELDS  per-field blink select.
- busy  out  1  high while a conversion is in flight.
- load_drop  out  1  one-cycle pulse when a load arrives while busy.
- overflow  out  1  high when any displayed field exceeded 99; updated at commit.
- seg  out  7  registered; active low; seg[0]=a ... seg[6]=g.
- an  out  2*N_FIELDS  registered; active-low one-hot anode select.

## Operation
- Digit map: digit 2f is the ones digit of field f and digit 2f+1 is its tens digit. Digit 0 is the rightmost digit.
- Conversion FSM has three states: IDLE, CONV and COMMIT. busy = (state != IDLE).
  - IDLE: when load=1, latch field_bus into a capture register, clear the field index and step counter, and go to CONV. Any change on field_bus after the latch has no effect on the conversion.
  - CONV: performs one double-dabble step per cycle on the current field. First add 3 to any BCD nibble that is >= 5, then shift left one bit.
  - CONV field end: after FIELD_W steps, write the field's tens and ones digits to a shadow register. If the captured value is greater than 99, write two dash codes instead and set that field's overflow bit in the shadow. Then advance to the next field, starting with field 0.
  - CONV exit: after field N_FIELDS-1 completes, go to COMMIT.
  - COMMIT: copy the whole shadow into the display registers and overflow in one cycle, then go to IDLE.
- A load while busy is ignored. load_drop pulses in the same cycle the load is sampled. No request is queued.
- Scan logic:
  - The refresh counter runs 0..REFRESH_DIV-1. On wrap it emits a tick.
  - Each tick advances the digit index 0..2*N_FIELDS-1 and wraps back to 0.
  - Each tick also advances the blink counter 0..BLINK_DIV-1. On that counter's wrap, the blink phase toggles.
- Output stage: each cycle, an[idx]=0 and all other anode bits are 1, and seg gets the decode of digit idx.
  - Blanking: if blink_en=1 and blink_mask[idx/2]=1 and phase=1, then an is all ones. seg still carries the decode.
- Decode codes (seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111.
- Leading zeros are always shown (clock style), so 5 displays as "05".

## Timing
- Reset values:
  - Control and counters: state=IDLE, busy=0, load_drop=0, overflow=0.
  - Scan state: idx=0, refresh counter=0, blink counter=0, phase=0.
  - Data and pins: display and shadow registers all 0, seg=1111111, an all ones.
- First cycle after reset release: an=...1110 and seg=1000000, because digit 0 holds zero.
- Conversion latency: load is sampled at edge T.
  - busy=1 from T+1 through T+N_FIELDS*FIELD_W+1.
  - COMMIT occurs in cycle T+N_FIELDS*FIELD_W+1.
  - busy=0 and the new digits are in the display registers from T+N_FIELDS*FIELD_W+2.
  - The new digits appear on seg one cycle later, when the digit is selected.
  - Defaults (N_FIELDS=2, FIELD_W=6): busy is high for 13 cycles.
- Back-to-back loads: a load in the first cycle with busy=0 is accepted.
- Digit slots: idx changes every REFRESH_DIV cycles. an/seg reflect the new idx one cycle after the tick.
- Blink: the phase toggles every REFRESH_DIV*BLINK_DIV cycles. blink_en and blink_mask are sampled every cycle, with no latching.
- rst during CONV or COMMIT: the conversion is aborted and the display registers clear to 0. A commit is never partial.
- A simultaneous load and rst: rst wins.

## Test plan
- Reset check: hold rst for 3 cycles, release -> busy=0, overflow=0, an=1110, seg=1000000 on the next cycle.
- Basic conversion: with defaults, field_bus={6'd12,6'd34}, pulse load -> busy high for exactly 13 cycles. Scan with REFRESH_DIV=4 shows digits 0..3 = 4,3,2,1, i.e. seg 0011001, 0110000, 0100100, 1111001.
- Overflow: FIELD_W=7, fields {7'd100, 7'd99}, load -> digits 9,9 then dash, dash; overflow=1. A following load of {7'd5, 7'd0} shows 0,0,5,0 and overflow=0.
- Drop: pulse load again 3 cycles after the first -> load_drop=1 for 1 cycle, and the first request's values are displayed.
- Blink: REFRESH_DIV=2, BLINK_DIV=2, blink_en=1, blink_mask=2'b10 -> an digits 2/3 are all ones during alternate 4-cycle windows; digits 0/1 are never blanked.
- Reset mid-conversion: assert rst 5 cycles after load -> busy=0 next cycle, the display shows zeros, and no commit occurs afterwards.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed common-anode 7-segment driver for the stopwatch.
// Each binary field is converted to two BCD digits by a multi-cycle
// shift-add-3 engine. The digits are collected in a shadow register and
// copied to the display registers in a single commit cycle. The digits are
// then scanned at a programmable refresh rate, and each field can blink.
//
// Parameters
//   N_FIELDS    number of binary fields (two digits each)
//   FIELD_W     bits per field, 4..7
//   REFRESH_DIV clk cycles per digit slot, >= 2
//   BLINK_DIV   refresh ticks per blink half-period, >= 1
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   field_bus   packed fields, field f at [f*FIELD_W +: FIELD_W]
//   load        single-cycle conversion request
//   blink_en    global blink enable
//   blink_mask  per-field blink select
//   busy        conversion in flight
//   load_drop   one-cycle pulse for a load rejected while busy
//   overflow    some displayed field was above 99 (updated at commit)
//   seg         active-low segments, seg[0]=a .. seg[6]=g (registered)
//   an          active-low one-hot anode select (registered)
//
// state  | meaning
// IDLE   | waiting for load; field_bus captured on load
// CONV   | one double-dabble step per cycle, field by field
// COMMIT | shadow digits and overflow copied to display in one cycle

module seg7_scan_driver #(
    parameter int N_FIELDS    = 2,
    parameter int FIELD_W     = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_FIELDS*FIELD_W-1:0] field_bus,
    input  logic                        load,
    input  logic                        blink_en,
    input  logic [N_FIELDS-1:0]         blink_mask,
    output logic                        busy,
    output logic                        load_drop,
    output logic                        overflow,
    output logic [6:0]                  seg,
    output logic [2*N_FIELDS-1:0]       an
);

    localparam int N_DIG  = 2 * N_FIELDS;
    localparam int IDX_W  = $clog2(N_DIG);
    localparam int FIDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int STEP_W = $clog2(FIELD_W);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [3:0] DASH = 4'hA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [N_FIELDS*FIELD_W-1:0] cap;
    logic [FIELD_W-1:0]          cap_f [N_FIELDS];
    logic [FIDX_W-1:0]           fidx;
    logic [STEP_W-1:0]           step;
    logic [STEP_W-1:0]           bit_sel;
    logic [FIELD_W-1:0]          cur_field;
    logic [3:0]                  ones, tens;
    logic                        hund;
    logic [3:0]                  ones_adj, tens_adj;
    logic [3:0]                  ones_next, tens_next;
    logic                        hund_next;
    logic                        last_step, last_field;

    logic [3:0]                  shadow_dig [N_DIG];
    logic [N_FIELDS-1:0]         shadow_ovf;
    logic [3:0]                  disp_dig [N_DIG];

    logic [REF_W-1:0]            ref_cnt;
    logic                        tick;
    logic [IDX_W-1:0]            idx;
    logic [BLK_W-1:0]            blk_cnt;
    logic                        phase;
    logic [N_DIG-1:0]            an_next;
    logic [6:0]                  seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            DASH:    seg_decode = 7'b0111111;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign busy = (state != IDLE);

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (last_step && last_field) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- double-dabble step ----------------
    always_comb begin
        for (int f = 0; f < N_FIELDS; f++) begin
            cap_f[f] = cap[f*FIELD_W +: FIELD_W];
        end
    end

    // The binary input is consumed MSB first straight out of the capture
    // register, so no separate binary shift register is needed. Any bit that
    // leaves the tens nibble makes the hundreds digit non-zero, which is
    // exactly the "value above 99" condition; it is kept as a sticky flag.
    always_comb begin
        cur_field  = cap_f[fidx];
        bit_sel    = STEP_W'(FIELD_W - 1) - step;
        ones_adj   = (ones >= 4'd5) ? ones + 4'd3 : ones;
        tens_adj   = (tens >= 4'd5) ? tens + 4'd3 : tens;
        hund_next  = hund | tens_adj[3];
        tens_next  = {tens_adj[2:0], ones_adj[3]};
        ones_next  = {ones_adj[2:0], cur_field[bit_sel]};
        last_step  = (step == STEP_W'(FIELD_W - 1));
        last_field = (fidx == FIDX_W'(N_FIELDS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap        <= '0;
            fidx       <= '0;
            step       <= '0;
            ones       <= '0;
            tens       <= '0;
            hund       <= 1'b0;
            shadow_ovf <= '0;
            overflow   <= 1'b0;
            load_drop  <= 1'b0;
            for (int d = 0; d < N_DIG; d++) begin
                shadow_dig[d] <= '0;
                disp_dig[d]   <= '0;
            end
        end else begin
            load_drop <= load && (state != IDLE);
            case (state)
                IDLE: begin
                    if (load) begin
                        cap  <= field_bus;
                        fidx <= '0;
                        step <= '0;
                        ones <= '0;
                        tens <= '0;
                        hund <= 1'b0;
                    end
                end
                CONV: begin
                    if (last_step) begin
                        shadow_dig[{fidx, 1'b0}] <= hund_next ? DASH : ones_next;
                        shadow_dig[{fidx, 1'b1}] <= hund_next ? DASH : tens_next;
                        shadow_ovf[fidx]         <= hund_next;
                        ones <= '0;
                        tens <= '0;
                        hund <= 1'b0;
                        step <= '0;
                        if (!last_field) fidx <= fidx + 1'b1;
                    end else begin
                        ones <= ones_next;
                        tens <= tens_next;
                        hund <= hund_next;
                        step <= step + 1'b1;
                    end
                end
                COMMIT: begin
                    disp_dig <= shadow_dig;
                    overflow <= |shadow_ovf;
                end
                default: ;
            endcase
        end
    end

    // ---------------- scan and output stage ----------------
    assign tick = (ref_cnt == REF_W'(REFRESH_DIV - 1));

    always_comb begin
        seg_next = seg_decode(disp_dig[idx]);
        an_next  = '1;
        // A blanked slot still carries its segment decode; only the anode is off.
        if (!(blink_en && blink_mask[idx[IDX_W-1:1]] && phase)) an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= '0;
            blk_cnt <= '0;
            phase   <= 1'b0;
            seg     <= 7'b1111111;
            an      <= '1;
        end else begin
            ref_cnt <= tick ? '0 : ref_cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + 1'b1;
                if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
                    blk_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver. Two instances: dut_a (FIELD_W=6,
// REFRESH_DIV=4) for conversion, drop and reset tests; dut_b (FIELD_W=7,
// REFRESH_DIV=2, BLINK_DIV=2) for overflow and blink tests.

module tb_seg7_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic        a_rst, a_load, a_ben;
    logic [11:0] a_fb;
    logic [1:0]  a_bmask;
    logic        a_busy, a_drop, a_ovf;
    logic [6:0]  a_seg;
    logic [3:0]  a_an;

    logic        b_rst, b_load, b_ben;
    logic [13:0] b_fb;
    logic [1:0]  b_bmask;
    logic        b_busy, b_drop, b_ovf;
    logic [6:0]  b_seg;
    logic [3:0]  b_an;

    seg7_scan_driver #(.N_FIELDS(2), .FIELD_W(6), .REFRESH_DIV(4), .BLINK_DIV(2)) dut_a (
        .clk(clk), .rst(a_rst), .field_bus(a_fb), .load(a_load),
        .blink_en(a_ben), .blink_mask(a_bmask),
        .busy(a_busy), .load_drop(a_drop), .overflow(a_ovf), .seg(a_seg), .an(a_an)
    );

    seg7_scan_driver #(.N_FIELDS(2), .FIELD_W(7), .REFRESH_DIV(2), .BLINK_DIV(2)) dut_b (
        .clk(clk), .rst(b_rst), .field_bus(b_fb), .load(b_load),
        .blink_en(b_ben), .blink_mask(b_bmask),
        .busy(b_busy), .load_drop(b_drop), .overflow(b_ovf), .seg(b_seg), .an(b_an)
    );

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G7 = 7'b1111000, G9 = 7'b0010000, GD = 7'b0111111;

    // an after the j-th edge following reset release (RD=2, 4 digits), by j%8
    logic [3:0] tab_mask10 [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                                   4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic [3:0] tab_plain  [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                                   4'b1011, 4'b1011, 4'b0111, 4'b0111};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input bit which);
        int n = 0;
        while (((which ? b_busy : a_busy) !== 1'b0) && n < 60) begin
            step(1);
            n++;
        end
        check("idle_timeout", 16'(n < 60), 16'd1);
    endtask

    task automatic scan_check(input bit which, input string tag,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [3:0] seen = 4'b0000;
        logic [3:0] an_s;
        logic [6:0] seg_s;
        for (int i = 0; i < 16; i++) begin
            step(1);
            an_s  = which ? b_an : a_an;
            seg_s = which ? b_seg : a_seg;
            case (an_s)
                4'b1110: begin check({tag, "_d0"}, seg_s, e0); seen[0] = 1'b1; end
                4'b1101: begin check({tag, "_d1"}, seg_s, e1); seen[1] = 1'b1; end
                4'b1011: begin check({tag, "_d2"}, seg_s, e2); seen[2] = 1'b1; end
                4'b0111: begin check({tag, "_d3"}, seg_s, e3); seen[3] = 1'b1; end
                default: check({tag, "_an_onehot"}, an_s, 4'b1110);
            endcase
        end
        check({tag, "_all_digits"}, seen, 4'b1111);
    endtask

    initial begin
        a_rst = 1'b1; a_load = 1'b0; a_ben = 1'b0; a_bmask = 2'b00; a_fb = '0;
        b_rst = 1'b1; b_load = 1'b0; b_ben = 1'b0; b_bmask = 2'b00; b_fb = '0;

        // reset
        step(3);
        a_rst = 1'b0; b_rst = 1'b0;
        step(1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_ovf", a_ovf, 1'b0);
        check("rst_drop", a_drop, 1'b0);
        check("rst_an", a_an, 4'b1110);
        check("rst_seg", a_seg, G0);
        check("rst_b_an", b_an, 4'b1110);
        check("rst_b_seg", b_seg, G0);

        // basic conversion: fields {12,34}, busy exactly 13 cycles
        a_fb = {6'd12, 6'd34}; a_load = 1'b1;
        step(1);
        a_load = 1'b0; a_fb = 12'hFFF;
        for (int k = 0; k < 13; k++) begin
            check("basic_busy_hi", a_busy, 1'b1);
            step(1);
        end
        check("basic_busy_lo", a_busy, 1'b0);
        scan_check(1'b0, "basic", G4, G3, G2, G1);
        check("basic_ovf", a_ovf, 1'b0);

        // drop: second load 3 cycles after the first is rejected
        a_fb = {6'd59, 6'd7}; a_load = 1'b1;
        step(1);
        a_load = 1'b0; a_fb = 12'hFFF;
        step(2);
        check("drop_pre", a_drop, 1'b0);
        a_fb = {6'd1, 6'd2}; a_load = 1'b1;
        step(1);
        a_load = 1'b0;
        check("drop_pulse", a_drop, 1'b1);
        step(1);
        check("drop_clear", a_drop, 1'b0);
        wait_idle(1'b0);
        scan_check(1'b0, "drop", G7, G0, G9, G5);

        // back-to-back: load accepted in the first idle cycle
        a_fb = {6'd45, 6'd8}; a_load = 1'b1;
        step(1);
        a_load = 1'b0;
        wait_idle(1'b0);
        a_fb = {6'd20, 6'd3}; a_load = 1'b1;
        step(1);
        a_load = 1'b0;
        check("b2b_busy", a_busy, 1'b1);
        check("b2b_nodrop", a_drop, 1'b0);
        wait_idle(1'b0);
        scan_check(1'b0, "b2b", G3, G0, G0, G2);

        // reset 5 cycles after load: abort, display cleared, no later commit
        a_fb = {6'd22, 6'd33}; a_load = 1'b1;
        step(1);
        a_load = 1'b0;
        step(4);
        a_rst = 1'b1;
        step(1);
        check("rstmid_busy", a_busy, 1'b0);
        a_rst = 1'b0;
        step(30);
        check("rstmid_busy_late", a_busy, 1'b0);
        check("rstmid_ovf", a_ovf, 1'b0);
        scan_check(1'b0, "rstmid", G0, G0, G0, G0);

        // overflow on the 7-bit instance
        b_fb = {7'd100, 7'd99}; b_load = 1'b1;
        step(1);
        b_load = 1'b0;
        wait_idle(1'b1);
        check("ovf_set", b_ovf, 1'b1);
        scan_check(1'b1, "ovf", G9, G9, GD, GD);
        b_fb = {7'd5, 7'd0}; b_load = 1'b1;
        step(1);
        b_load = 1'b0;
        wait_idle(1'b1);
        check("ovf_clr", b_ovf, 1'b0);
        scan_check(1'b1, "noovf", G0, G0, G5, G0);

        // blink: restart scan counters so the phase is known
        b_rst = 1'b1;
        step(2);
        b_ben = 1'b1; b_bmask = 2'b10; b_rst = 1'b0;
        for (int j = 0; j < 16; j++) begin
            step(1);
            check("blink_m10", b_an, tab_mask10[j % 8]);
        end
        b_ben = 1'b0;
        for (int j = 16; j < 24; j++) begin
            step(1);
            check("blink_off", b_an, tab_plain[j % 8]);
        end
        b_ben = 1'b1; b_bmask = 2'b01;
        for (int j = 24; j < 32; j++) begin
            step(1);
            check("blink_m01", b_an, tab_plain[j % 8]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no end of test, expected finish before 300000");
        $fatal(1, "timeout");
    end

endmodule
